// File: rtl/alu_out_capture_buffer_hdl_pkg.sv
// Shared types and constants for the alu_out capture buffer.
package alu_out_capture_pkg_hdl;

  // Per-channel drop counters saturate instead of wrapping.
  localparam int         DROP_W   = 8;
  localparam logic [7:0] DROP_MAX = 8'd255;

  // Default field widths of a captured event.
  localparam int DEF_CH_W     = 2;
  localparam int DEF_RESULT_W = 16;
  localparam int DEF_TS_W     = 16;

  // One captured event as it sits in the shared FIFO (default widths).
  typedef struct packed {
    logic [DEF_CH_W-1:0]     chan;
    logic [DEF_RESULT_W-1:0] result;
    logic [DEF_TS_W-1:0]     timestamp;
  } alu_out_capture_entry_s;

  // Channel-tag width; a single channel still needs one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_out_capture_buffer_hdl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner.
module alu_out_rr_arbiter
  import alu_out_capture_pkg_hdl::*;
#(
  parameter int N = 4,
  parameter int W = ch_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid
);

  logic [W-1:0] ptr;

  // Search requesters starting at the pointer, wrapping modulo N.
  always_comb begin
    int idx;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (en && !gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = W'(idx);
        gnt[idx]  = 1'b1;
      end
    end
  end

  // Pointer advances only when something was granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_valid) begin
      ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + W'(1);
    end
  end

endmodule

// File: rtl/alu_out_capture_buffer_hdl.sv
// Capture buffer: timestamps per-channel alu_out events into holding
// registers, arbitrates them round-robin into a shared FWFT FIFO, and
// counts events lost because a channel's holding register was occupied.
//
// Drain handshake: the head is offered while txn_valid is high and leaves
// the FIFO on a clock edge where txn_valid && txn_ready; while txn_valid is
// high and txn_ready is low the txn_* outputs do not change, and txn_ready
// with txn_valid low has no effect.
module alu_out_capture_buffer_hdl
  import alu_out_capture_pkg_hdl::*;
#(
  parameter int RESULT_WIDTH = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int TS_WIDTH     = 16,
  parameter int CH_W         = ch_width(NUM_CHANNELS),
  parameter int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CHANNELS-1:0]          alu_out_done,
  input  logic [NUM_CHANNELS*RESULT_WIDTH-1:0] alu_out_result,
  output logic                             txn_valid,
  input  logic                             txn_ready,
  output logic [CH_W-1:0]                  txn_chan,
  output logic [RESULT_WIDTH-1:0]          txn_result,
  output logic [TS_WIDTH-1:0]              txn_timestamp,
  output logic [LVL_W-1:0]                 fifo_level,
  output logic [NUM_CHANNELS*DROP_W-1:0]   drop_count,
  input  logic                             clear_drops
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [TS_WIDTH-1:0]     ts;
  logic [NUM_CHANNELS-1:0] hold_valid;
  logic [RESULT_WIDTH-1:0] hold_result [NUM_CHANNELS];
  logic [TS_WIDTH-1:0]     hold_ts     [NUM_CHANNELS];
  logic [DROP_W-1:0]       drop_q      [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] gnt;
  logic [CH_W-1:0]         gnt_idx;
  logic                    gnt_valid;
  logic                    arb_en;

  logic [CH_W-1:0]         mem_chan   [FIFO_DEPTH];
  logic [RESULT_WIDTH-1:0] mem_result [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]     mem_ts     [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [LVL_W-1:0]        level;
  logic                    push;
  logic                    pop;

  // A slot is only considered free from the registered level, so a pop in
  // the same cycle never makes room for a push.
  assign arb_en = (level < LVL_W'(FIFO_DEPTH));
  assign push   = gnt_valid;
  assign pop    = txn_valid && txn_ready;

  alu_out_rr_arbiter #(
    .N (NUM_CHANNELS),
    .W (CH_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (hold_valid),
    .en        (arb_en),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Free-running timestamp, wraps naturally at 2^TS_WIDTH.
  always_ff @(posedge clk) begin
    if (rst) ts <= '0;
    else     ts <= ts + TS_WIDTH'(1);
  end

  // Holding registers: load when empty or being drained this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        hold_result[i] <= '0;
        hold_ts[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (alu_out_done[i] && (!hold_valid[i] || gnt[i])) begin
          hold_valid[i]  <= 1'b1;
          hold_result[i] <= alu_out_result[i*RESULT_WIDTH +: RESULT_WIDTH];
          hold_ts[i]     <= ts;
        end else if (gnt[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Saturating drop counters; clear wins over a simultaneous drop.
  always_ff @(posedge clk) begin
    if (rst || clear_drops) begin
      for (int i = 0; i < NUM_CHANNELS; i++) drop_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (alu_out_done[i] && hold_valid[i] && !gnt[i] && drop_q[i] != DROP_MAX)
          drop_q[i] <= drop_q[i] + DROP_W'(1);
      end
    end
  end

  // FIFO storage write; contents need no reset since level gates the head.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_chan[wr_ptr]   <= gnt_idx;
      mem_result[wr_ptr] <= hold_result[gnt_idx];
      mem_ts[wr_ptr]     <= hold_ts[gnt_idx];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign txn_valid     = (level != '0);
  assign txn_chan      = txn_valid ? mem_chan[rd_ptr]   : '0;
  assign txn_result    = txn_valid ? mem_result[rd_ptr] : '0;
  assign txn_timestamp = txn_valid ? mem_ts[rd_ptr]     : '0;
  assign fifo_level    = level;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_drop
    assign drop_count[g*DROP_W +: DROP_W] = drop_q[g];
  end

endmodule

// File: tb/tb_alu_out_capture_buffer_hdl.sv
// Directed bench for alu_out_capture_buffer_hdl: a vector table for
// round-robin draining plus hand-written multi-cycle sequences.
module tb_alu_out_capture_buffer_hdl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance (defaults)
  logic [3:0]  done   = '0;
  logic [63:0] result = '0;
  logic        ready  = 1'b0;
  logic        clear  = 1'b0;
  logic        txn_valid;
  logic [1:0]  txn_chan;
  logic [15:0] txn_result;
  logic [15:0] txn_timestamp;
  logic [3:0]  fifo_level;
  logic [31:0] drop_count;

  // narrow-timestamp instance for wrap checks
  logic [3:0]  done_w   = '0;
  logic [63:0] result_w = '0;
  logic        ready_w  = 1'b1;
  logic        clear_w  = 1'b0;
  logic        txn_valid_w;
  logic [1:0]  txn_chan_w;
  logic [15:0] txn_result_w;
  logic [3:0]  txn_timestamp_w;
  logic [3:0]  fifo_level_w;
  logic [31:0] drop_count_w;

  alu_out_capture_buffer_hdl dut (
    .clk(clk), .rst(rst), .alu_out_done(done), .alu_out_result(result),
    .txn_valid(txn_valid), .txn_ready(ready), .txn_chan(txn_chan),
    .txn_result(txn_result), .txn_timestamp(txn_timestamp),
    .fifo_level(fifo_level), .drop_count(drop_count), .clear_drops(clear)
  );

  alu_out_capture_buffer_hdl #(.TS_WIDTH(4)) dut_w (
    .clk(clk), .rst(rst), .alu_out_done(done_w), .alu_out_result(result_w),
    .txn_valid(txn_valid_w), .txn_ready(ready_w), .txn_chan(txn_chan_w),
    .txn_result(txn_result_w), .txn_timestamp(txn_timestamp_w),
    .fifo_level(fifo_level_w), .drop_count(drop_count_w), .clear_drops(clear_w)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;   // bench model of the timestamp counter
  logic [15:0] exp_q[$];
  logic [15:0] exp_ts_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    if (rst) cyc = 0;
    else     cyc = cyc + 1;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  done;
    logic [63:0] res;
    logic        ready;
    logic        exp_valid;
    logic [1:0]  exp_chan;
    logic [15:0] exp_result;
    logic [15:0] exp_ts;
    logic [3:0]  exp_level;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // round-robin bursts: burst 1 captured at ts 0, burst 2 at ts 5
    vecs[0]  = '{4'hF, 64'h0004_0003_0002_0001, 1'b1, 1'b0, 2'd0, 16'h0, 16'd0, 4'd0};
    vecs[1]  = '{4'h0, 64'h0,                   1'b1, 1'b1, 2'd0, 16'h1, 16'd0, 4'd1};
    vecs[2]  = '{4'h0, 64'h0,                   1'b1, 1'b1, 2'd1, 16'h2, 16'd0, 4'd1};
    vecs[3]  = '{4'h0, 64'h0,                   1'b1, 1'b1, 2'd2, 16'h3, 16'd0, 4'd1};
    vecs[4]  = '{4'h0, 64'h0,                   1'b1, 1'b1, 2'd3, 16'h4, 16'd0, 4'd1};
    vecs[5]  = '{4'hF, 64'h0008_0007_0006_0005, 1'b1, 1'b0, 2'd0, 16'h0, 16'd0, 4'd0};
    vecs[6]  = '{4'h0, 64'h0,                   1'b1, 1'b1, 2'd0, 16'h5, 16'd5, 4'd1};
    vecs[7]  = '{4'h0, 64'h0,                   1'b1, 1'b1, 2'd1, 16'h6, 16'd5, 4'd1};
    vecs[8]  = '{4'h0, 64'h0,                   1'b1, 1'b1, 2'd2, 16'h7, 16'd5, 4'd1};
    vecs[9]  = '{4'h0, 64'h0,                   1'b1, 1'b1, 2'd3, 16'h8, 16'd5, 4'd1};
    vecs[10] = '{4'h0, 64'h0,                   1'b1, 1'b0, 2'd0, 16'h0, 16'd0, 4'd0};

    // ---- reset state ----
    do_reset();
    chk("rst_valid", txn_valid, 0);
    chk("rst_chan", txn_chan, 0);
    chk("rst_result", txn_result, 0);
    chk("rst_ts", txn_timestamp, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_drops", drop_count, 0);

    // ---- single event, 2-edge latency ----
    repeat (5) tick();
    done = 4'b0100;
    result = 64'h0;
    result[47:32] = 16'h00A5;
    tick();
    done = '0;
    chk("single_early_valid", txn_valid, 0);
    tick();
    chk("single_valid", txn_valid, 1);
    chk("single_chan", txn_chan, 2);
    chk("single_result", txn_result, 16'h00A5);
    chk("single_ts", txn_timestamp, 5);
    chk("single_level", fifo_level, 1);

    // ---- round-robin table ----
    do_reset();
    for (int v = 0; v < 11; v++) begin
      done = vecs[v].done;
      result = vecs[v].res;
      ready = vecs[v].ready;
      tick();
      chk($sformatf("rr%0d_valid", v), txn_valid, vecs[v].exp_valid);
      chk($sformatf("rr%0d_chan", v), txn_chan, vecs[v].exp_chan);
      chk($sformatf("rr%0d_result", v), txn_result, vecs[v].exp_result);
      chk($sformatf("rr%0d_ts", v), txn_timestamp, vecs[v].exp_ts);
      chk($sformatf("rr%0d_level", v), fifo_level, vecs[v].exp_level);
    end
    done = '0;

    // ---- full FIFO / backpressure ----
    do_reset();
    ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      done = 4'b0010;
      result = 64'h0;
      result[31:16] = 16'h0100 + 16'(k);
      if (k <= 9) begin
        exp_q.push_back(16'h0100 + 16'(k));
        exp_ts_q.push_back(16'(cyc));
      end
      tick();
    end
    done = '0;
    tick();
    chk("full_level", fifo_level, 8);
    chk("full_drop1", drop_count[15:8], 1);
    chk("full_drop_others", {drop_count[31:16], drop_count[7:0]}, 0);
    chk("full_head_result", txn_result, 16'h0101);
    repeat (3) tick();
    chk("stall_valid", txn_valid, 1);
    chk("stall_chan", txn_chan, 1);
    chk("stall_result", txn_result, 16'h0101);
    chk("stall_ts", txn_timestamp, exp_ts_q[0]);
    chk("stall_level", fifo_level, 8);
    ready = 1'b1;
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      if (txn_valid) begin
        chk("drain_chan", txn_chan, 1);
        chk("drain_result", txn_result, exp_q.pop_front());
        chk("drain_ts", txn_timestamp, exp_ts_q.pop_front());
      end
      tick();
    end
    chk("drain_remaining", exp_q.size(), 0);
    chk("drain_level", fifo_level, 0);
    ready = 1'b0;

    // ---- timestamp wrap on the 4-bit instance ----
    do_reset();
    for (int c = 0; c < 20 && (cyc % 16) != 15; c++) tick();
    done_w = 4'b0001;
    result_w = 64'h11;
    tick();
    result_w = 64'h22;
    tick();
    done_w = '0;
    chk("wrap_first_result", txn_result_w, 16'h11);
    chk("wrap_first_ts", txn_timestamp_w, 15);
    tick();
    chk("wrap_second_result", txn_result_w, 16'h22);
    chk("wrap_second_ts", txn_timestamp_w, 0);

    // ---- reset mid-operation with 3 queued entries ----
    do_reset();
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      done = 4'b1000;
      result = 64'h0;
      result[63:48] = 16'h0031 + 16'(k);
      tick();
    end
    done = '0;
    repeat (2) tick();
    chk("mid_level_before", fifo_level, 3);
    do_reset();
    chk("mid_valid", txn_valid, 0);
    chk("mid_level", fifo_level, 0);
    chk("mid_result", txn_result, 0);
    repeat (2) tick();
    done = 4'b0010;
    result = 64'h0;
    result[31:16] = 16'h0077;
    tick();
    done = '0;
    tick();
    chk("post_rst_chan", txn_chan, 1);
    chk("post_rst_result", txn_result, 16'h0077);
    chk("post_rst_ts", txn_timestamp, 2);
    chk("post_rst_level", fifo_level, 1);

    // ---- drop saturation, clear priority, reset clears counters ----
    do_reset();
    ready = 1'b0;
    done = 4'b0001;
    result = 64'h0;
    repeat (310) tick();
    chk("sat_drop0", drop_count[7:0], 255);
    chk("sat_drop_others", drop_count[31:8], 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_wins", drop_count[7:0], 0);
    tick();
    chk("drop_after_clear", drop_count[7:0], 1);
    done = '0;
    do_reset();
    chk("rst_full_level", fifo_level, 0);
    chk("rst_full_valid", txn_valid, 0);
    chk("rst_full_drops", drop_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
